// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter sharing one single-port BRAM controller
// among NUM_REQ requesters. Supports bounded locked bursts and steers the
// 1-cycle-latency read data back to the requester that issued the read.
module bram_arbiter #(
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DAT_WIDTH-1:0]  req_dat,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [DAT_WIDTH-1:0]          rsp_dat,
  output logic [NUM_REQ-1:0]            rsp_val,
  output logic [ADDR_WIDTH-1:0]         ctrl_addr,
  output logic                          ctrl_wren,
  output logic [DAT_WIDTH-1:0]          ctrl_idat,
  output logic                          ctrl_rden,
  input  logic [DAT_WIDTH-1:0]          ctrl_odat,
  input  logic                          ctrl_oval,
  output logic [ID_WIDTH-1:0]           owner_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  // Registered arbitration / read-tracking state
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] owner_id_q, owner_id_d;
  logic                lock_own_q, lock_own_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [ID_WIDTH-1:0] rd_id_q, rd_id_d;

  // Arbitration results
  logic                gnt_any_s;
  logic                gnt_en_s;
  logic                use_lock_s;
  logic [ID_WIDTH-1:0] gnt_idx_s;
  logic [ID_WIDTH-1:0] cand_s;

  // Unpacked views of the packed per-requester address/data buses
  logic [ADDR_WIDTH-1:0] addr_arr_s [NUM_REQ];
  logic [DAT_WIDTH-1:0]  dat_arr_s  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr_s[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_arr_s[g]  = req_dat[g*DAT_WIDTH +: DAT_WIDTH];
  end

  // Pick the winner: locked owner while its burst budget lasts, else round-robin scan
  always_comb begin
    gnt_any_s  = 1'b0;
    use_lock_s = 1'b0;
    gnt_idx_s  = owner_id_q;
    cand_s     = owner_id_q;
    if (lock_own_q && req_vld[owner_id_q] && (burst_cnt_q < MAX_CNT)) begin
      gnt_any_s  = 1'b1;
      use_lock_s = 1'b1;
    end else begin
      // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
      for (int off = NUM_REQ; off >= 1; off--) begin
        cand_s = ID_WIDTH'((int'(rr_ptr_q) + off) % NUM_REQ);
        if (req_vld[cand_s]) begin
          gnt_any_s = 1'b1;
          gnt_idx_s = cand_s;
        end else begin
          gnt_any_s = gnt_any_s;
        end
      end
    end
  end

  // Grants and controller strobes are suppressed while reset is held
  assign gnt_en_s = gnt_any_s & rst;

  // Drive the one-hot grant and the controller command from the winner
  always_comb begin
    req_gnt            = {NUM_REQ{1'b0}};
    req_gnt[gnt_idx_s] = gnt_en_s;
    ctrl_addr          = addr_arr_s[gnt_idx_s];
    ctrl_idat          = dat_arr_s[gnt_idx_s];
    ctrl_wren          = gnt_en_s & req_wr[gnt_idx_s];
    ctrl_rden          = gnt_en_s & ~req_wr[gnt_idx_s];
  end

  // Next-state for pointer, ownership, burst count and pending-read tracking
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_id_d  = owner_id_q;
    lock_own_d  = lock_own_q;
    burst_cnt_d = burst_cnt_q;
    rd_pend_d   = 1'b0;
    rd_id_d     = rd_id_q;
    if (gnt_en_s) begin
      rr_ptr_d    = gnt_idx_s;
      owner_id_d  = gnt_idx_s;
      lock_own_d  = req_lock[gnt_idx_s];
      burst_cnt_d = use_lock_s ? (burst_cnt_q + ONE_CNT) : ONE_CNT;
      rd_pend_d   = ~req_wr[gnt_idx_s];
      rd_id_d     = req_wr[gnt_idx_s] ? rd_id_q : gnt_idx_s;
    end else begin
      rd_pend_d   = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= LAST_ID;
      owner_id_q  <= {ID_WIDTH{1'b0}};
      lock_own_q  <= 1'b0;
      burst_cnt_q <= {CNT_W{1'b0}};
      rd_pend_q   <= 1'b0;
      rd_id_q     <= {ID_WIDTH{1'b0}};
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_id_q  <= owner_id_d;
      lock_own_q  <= lock_own_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_id_q     <= rd_id_d;
    end
  end

  // Steer returning read data to the requester that owns the in-flight read;
  // an unexpected ctrl_oval (nothing pending) is ignored.
  always_comb begin
    rsp_val          = {NUM_REQ{1'b0}};
    rsp_val[rd_id_q] = ctrl_oval & rd_pend_q;
  end

  assign rsp_dat  = ctrl_odat;
  assign owner_id = owner_id_q;
  assign busy     = rd_pend_q | (|req_vld);

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: table-driven arbitration vectors plus
// directed sequences for reads, pipelined reads, bursts, write-first and reset.
module tb_bram_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_vld, req_wr, req_lock;
  logic [31:0]  a_r [4];
  logic [31:0]  d_r [4];
  logic [127:0] req_addr, req_dat;
  logic [3:0]   req_gnt, rsp_val;
  logic [31:0]  rsp_dat, ctrl_addr, ctrl_idat, ctrl_odat;
  logic         ctrl_wren, ctrl_rden, ctrl_oval, busy;
  logic [1:0]   owner_id;

  // Behavioural BRAM: 1-cycle read latency, preloaded while reset is low
  logic [31:0]  mem [256];
  logic [31:0]  model_odat;
  logic         model_oval;
  logic         force_oval;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] wr;
    logic [3:0] lock;
    logic [3:0] exp_gnt;
  } vec_t;
  vec_t tbl [12];

  assign req_addr  = {a_r[3], a_r[2], a_r[1], a_r[0]};
  assign req_dat   = {d_r[3], d_r[2], d_r[1], d_r[0]};
  assign ctrl_odat = model_odat;
  assign ctrl_oval = model_oval | force_oval;

  bram_arbiter dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_wr(req_wr), .req_lock(req_lock),
    .req_addr(req_addr), .req_dat(req_dat),
    .req_gnt(req_gnt), .rsp_dat(rsp_dat), .rsp_val(rsp_val),
    .ctrl_addr(ctrl_addr), .ctrl_wren(ctrl_wren), .ctrl_idat(ctrl_idat),
    .ctrl_rden(ctrl_rden), .ctrl_odat(ctrl_odat), .ctrl_oval(ctrl_oval),
    .owner_id(owner_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h00] <= 32'h0000000A;
      mem[8'h01] <= 32'h0000000B;
    end else if (ctrl_wren) begin
      mem[ctrl_addr[7:0]] <= ctrl_idat;
    end
    model_oval <= ctrl_rden;
    if (ctrl_rden) model_odat <= mem[ctrl_addr[7:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  exp_g;
    logic [3:0]  prev_g;
    logic [31:0] n1;
    n_tests = 0;
    n_fail  = 0;
    force_oval = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_r[i] = 32'h80 + 32'(i);
      d_r[i] = 32'h1000 + 32'(i);
    end

    // vld, wr, lock, expected grant
    tbl[0]  = '{4'hF, 4'hF, 4'h0, 4'b0001};
    tbl[1]  = '{4'hF, 4'hF, 4'h0, 4'b0010};
    tbl[2]  = '{4'hF, 4'hF, 4'h0, 4'b0100};
    tbl[3]  = '{4'hF, 4'hF, 4'h0, 4'b1000};
    tbl[4]  = '{4'hF, 4'hF, 4'h0, 4'b0001};
    tbl[5]  = '{4'b1010, 4'hF, 4'h0, 4'b0010};
    tbl[6]  = '{4'b1010, 4'hF, 4'h0, 4'b1000};
    tbl[7]  = '{4'b0001, 4'hF, 4'h0, 4'b0001};
    tbl[8]  = '{4'b0000, 4'hF, 4'h0, 4'b0000};
    tbl[9]  = '{4'b0110, 4'hF, 4'b0010, 4'b0010};
    tbl[10] = '{4'b0110, 4'hF, 4'b0010, 4'b0010};
    tbl[11] = '{4'b0100, 4'hF, 4'h0, 4'b0100};

    // Reset held with all requesters valid
    rst = 1'b0; req_vld = 4'hF; req_wr = 4'hF; req_lock = 4'h0;
    cyc(); cyc();
    #2;
    chk("rst_gnt", req_gnt, 4'h0);
    chk("rst_wren", ctrl_wren, 1'b0);
    chk("rst_rden", ctrl_rden, 1'b0);
    chk("rst_owner", owner_id, 2'd0);
    chk("rst_rspval", rsp_val, 4'h0);
    #1;

    // Table-driven arbitration sequence starting right after reset release
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_vld = tbl[i].vld; req_wr = tbl[i].wr; req_lock = tbl[i].lock;
      #2;
      chk($sformatf("tbl%0d_gnt", i), req_gnt, tbl[i].exp_gnt);
      chk($sformatf("tbl%0d_wren", i), ctrl_wren, |(tbl[i].wr & tbl[i].exp_gnt));
      chk($sformatf("tbl%0d_rden", i), ctrl_rden, |(~tbl[i].wr & tbl[i].exp_gnt));
      cyc();
    end

    // Single read by requester 2 from 0x10
    req_vld = 4'b0100; req_wr = 4'h0; req_lock = 4'h0; a_r[2] = 32'h10;
    #2;
    chk("rd2_gnt", req_gnt, 4'b0100);
    chk("rd2_rden", ctrl_rden, 1'b1);
    chk("rd2_addr", ctrl_addr, 32'h10);
    cyc();
    req_vld = 4'h0;
    #2;
    chk("rd2_rspval", rsp_val, 4'b0100);
    chk("rd2_rspdat", rsp_dat, 32'hDEADBEEF);
    chk("rd2_busy", busy, 1'b1);
    cyc();
    #2;
    chk("rd2_rspval_clr", rsp_val, 4'h0);
    chk("idle_busy", busy, 1'b0);

    // Alternating pipelined reads from requesters 0 and 1
    a_r[0] = 32'h0; a_r[1] = 32'h1;
    prev_g = 4'h0;
    for (int k = 0; k < 4; k++) begin
      req_vld = 4'b0011; req_wr = 4'h0;
      #2;
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      chk($sformatf("alt%0d_gnt", k), req_gnt, exp_g);
      chk($sformatf("alt%0d_rden", k), ctrl_rden, 1'b1);
      if (k > 0) begin
        chk($sformatf("alt%0d_rspval", k), rsp_val, prev_g);
        chk($sformatf("alt%0d_rspdat", k), rsp_dat, (prev_g == 4'b0001) ? 32'hA : 32'hB);
      end
      prev_g = exp_g;
      cyc();
    end
    req_vld = 4'h0;
    #2;
    chk("alt_last_rspval", rsp_val, 4'b0010);
    chk("alt_last_rspdat", rsp_dat, 32'hB);
    cyc();

    // Locked burst of 20 writes by requester 1 while requester 3 waits
    n1 = 32'd0;
    a_r[3] = 32'h60; d_r[3] = 32'h3333;
    for (int c = 1; c <= 22; c++) begin
      req_vld = {(c >= 2 && c <= 17), 1'b0, (c <= 21), 1'b0};
      req_wr  = 4'b1010;
      req_lock = {2'b00, (c <= 20), 1'b0};
      a_r[1] = 32'h40 + n1; d_r[1] = 32'h500 + n1;
      #2;
      if (c <= 16 || (c >= 18 && c <= 21)) exp_g = 4'b0010;
      else if (c == 17) exp_g = 4'b1000;
      else exp_g = 4'b0000;
      chk($sformatf("burst%0d_gnt", c), req_gnt, exp_g);
      chk($sformatf("burst%0d_wren", c), ctrl_wren, exp_g != 4'h0);
      if (exp_g == 4'b0010) begin
        chk($sformatf("burst%0d_addr", c), ctrl_addr, 32'h40 + n1);
        n1 = n1 + 32'd1;
      end else if (exp_g == 4'b1000) begin
        chk("burst_r3_addr", ctrl_addr, 32'h60);
      end
      cyc();
    end
    chk("burst_total", n1, 32'd20);

    // Write 0x55 to addr 4 by req 0, then read it back by req 1
    req_vld = 4'b0001; req_wr = 4'b0001; a_r[0] = 32'h4; d_r[0] = 32'h55;
    #2;
    chk("wf_wr_gnt", req_gnt, 4'b0001);
    chk("wf_wr_wren", ctrl_wren, 1'b1);
    chk("wf_wr_idat", ctrl_idat, 32'h55);
    cyc();
    req_vld = 4'b0010; req_wr = 4'b0000; a_r[1] = 32'h4;
    #2;
    chk("wf_rd_gnt", req_gnt, 4'b0010);
    chk("wf_rd_rden", ctrl_rden, 1'b1);
    cyc();
    req_vld = 4'h0;
    #2;
    chk("wf_rspval", rsp_val, 4'b0010);
    chk("wf_rspdat", rsp_dat, 32'h55);
    cyc();

    // Reset asserted one cycle after a read grant drops the response
    req_vld = 4'b0100; req_wr = 4'h0; a_r[2] = 32'h10;
    #2;
    chk("rr_gnt", req_gnt, 4'b0100);
    cyc();
    rst = 1'b0; req_vld = 4'hF; req_wr = 4'hF;
    #2;
    chk("rr_oval_seen", ctrl_oval, 1'b1);
    chk("rr_rspval", rsp_val, 4'h0);
    chk("rr_gnt_rst", req_gnt, 4'h0);
    chk("rr_owner", owner_id, 2'd0);
    cyc();
    rst = 1'b1;
    #2;
    chk("rr_first_gnt", req_gnt, 4'b0001);
    chk("rr_rspval_rel", rsp_val, 4'h0);
    cyc();

    // Spurious ctrl_oval with nothing pending is ignored
    req_vld = 4'h0; force_oval = 1'b1;
    #2;
    chk("spur_rspval", rsp_val, 4'h0);
    cyc();
    force_oval = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
